axil_lsu_master: RTL and testbench

//  AXI-Lite initiator: turns a single-outstanding CPU memory request (valid/ready) into AXI-Lite
//  AR/R or AW/W/B transactions and returns one response to the CPU. Sits between IFU/LSU and the
//  AXI-Lite SRAM/xbar; one transaction in flight, no bursts, no reordering.

---
 rtl/ysyx_23060061_axil_pkg.sv | 25 ++
 rtl/axil_lsu_master.sv | 225 ++++++++++++++++++++++
 tb/tb_axil_lsu_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060061_axil_pkg.sv
// Shared AXI-Lite definitions: response codes, FSM state encoding and a
// response-decoding helper. The AXI-Lite SRAM slave uses the same package.
// Contents: RESP_* codes, axil_state_t (3-bit), resp_is_err().
package ysyx_23060061_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_RESP = 3'd4,
      ST_RSP     = 3'd5
   } axil_state_t;

   // Anything other than OKAY is reported to the CPU as an error
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/axil_lsu_master.sv
// AXI-Lite initiator: one CPU request (valid/ready) -> one AR/R or AW/W/B transaction -> one response.
// Latency: zero-wait read accepted at N gives AR at N+1, R at N+2, rsp_valid at N+3; all outputs registered.
// Backpressure: single outstanding; req_ready low until rsp taken; AXI valids never wait on same-cycle ready.
// Ports: clk/rst (async active-low); CPU req_*/rsp_*; AXI-Lite AR, R, AW, W, B channels.
// Build option: AXIL_MST_TIMEOUT_EN adds an abort counter (TIMEOUT_CYCLES) and a sticky slave-failed flag.
module axil_lsu_master
   import ysyx_23060061_axil_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   // CPU request
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   // CPU response
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   // AXI-Lite read
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready,
   // AXI-Lite write
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   axil_state_t         r_state;
   logic                r_req_ready;
   logic                r_arvalid;
   logic                r_rready;
   logic                r_awvalid;
   logic                r_wvalid;
   logic                r_bready;
   logic                r_rsp_valid;
   logic                r_rsp_err;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_wstrb;
   logic                r_aw_done;
   logic                r_w_done;

   // A channel counts as finished if it completed earlier or completes now
   logic w_aw_fin;
   logic w_w_fin;
   assign w_aw_fin = r_aw_done | (r_awvalid & awready);
   assign w_w_fin  = r_w_done  | (r_wvalid  & wready);

`ifdef AXIL_MST_TIMEOUT_EN
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_slv_failed;
   logic             w_busy;

   assign w_busy = (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA) ||
                   (r_state == ST_WR_REQ)  || (r_state == ST_WR_RESP);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b1;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
`ifdef AXIL_MST_TIMEOUT_EN
         r_cnt        <= '0;
         r_slv_failed <= 1'b0;
`endif
      end else begin
`ifdef AXIL_MST_TIMEOUT_EN
         // Counts the cycles of the current transaction; zero outside it
         r_cnt <= w_busy ? r_cnt + 1'b1 : '0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_wstrb     <= req_wstrb;
                  r_req_ready <= 1'b0;
`ifdef AXIL_MST_TIMEOUT_EN
                  // Slave already timed out once: fail fast without touching the bus
                  if (r_slv_failed) begin
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RSP;
                  end else
`endif
                  if (req_wen) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WR_REQ;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RD_ADDR;
                  end
               end
            end

            ST_RD_ADDR: begin
               if (arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_DATA;
               end
            end

            ST_RD_DATA: begin
               if (rvalid) begin
                  r_rsp_rdata <= rdata;
                  r_rsp_err   <= resp_is_err(rresp);
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RSP;
               end
            end

            ST_WR_REQ: begin
               if (r_awvalid && awready) r_awvalid <= 1'b0;
               if (r_wvalid && wready)   r_wvalid  <= 1'b0;
               if (w_aw_fin && w_w_fin) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= ST_WR_RESP;
               end else begin
                  r_aw_done <= w_aw_fin;
                  r_w_done  <= w_w_fin;
               end
            end

            ST_WR_RESP: begin
               if (bvalid) begin
                  r_rsp_err   <= resp_is_err(bresp);
                  r_rsp_rdata <= '0;
                  r_bready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RSP;
               end
            end

            ST_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase

`ifdef AXIL_MST_TIMEOUT_EN
         // Abort overrides whatever the state logic decided this cycle
         if (w_busy && (r_cnt == CNT_LAST)) begin
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_rsp_err    <= 1'b1;
            r_rsp_rdata  <= '0;
            r_rsp_valid  <= 1'b1;
            r_slv_failed <= 1'b1;
            r_state      <= ST_RSP;
         end
`endif
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign araddr    = r_addr;
   assign arvalid   = r_arvalid;
   assign rready    = r_rready;
   assign awaddr    = r_addr;
   assign awvalid   = r_awvalid;
   assign wdata     = r_wdata;
   assign wstrb     = r_wstrb;
   assign wvalid    = r_wvalid;
   assign bready    = r_bready;

endmodule

// File: tb/tb_axil_lsu_master.sv
// Directed bench for axil_lsu_master: bench drives the AXI-Lite slave side cycle by cycle.
// Inputs change and outputs are sampled on the falling edge.
module tb_axil_lsu_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  rresp, bresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   axil_lsu_master #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      rsp_ready = 0;
      arready = 0; rdata = '0; rresp = 2'b00; rvalid = 0;
      awready = 0; wready = 0; bresp = 2'b00; bvalid = 0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_req_ready", req_ready, 1);
      check("rst_arvalid",   arvalid, 0);
      check("rst_awvalid",   awvalid, 0);
      check("rst_wvalid",    wvalid, 0);
      check("rst_rready",    rready, 0);
      check("rst_bready",    bready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err",   rsp_err, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_araddr",    araddr, 0);
      rst = 1'b1;
      tick();

      // 1: zero-wait read, rsp_valid at N+3
      req_valid = 1; req_wen = 0; req_addr = 32'h8000_0000;
      tick();                                    // N accepted
      req_valid = 0;
      check("t1_req_ready", req_ready, 0);
      check("t1_arvalid",   arvalid, 1);         // N+1
      check("t1_araddr",    araddr, 32'h8000_0000);
      arready = 1;
      tick();
      arready = 0;
      check("t1_arvalid_drop", arvalid, 0);
      check("t1_rready",       rready, 1);
      check("t1_rsp_early",    rsp_valid, 0);
      rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
      tick();
      rvalid = 0;
      check("t1_rsp_valid", rsp_valid, 1);       // N+3
      check("t1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("t1_rsp_err",   rsp_err, 0);
      check("t1_rready_drop", rready, 0);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      check("t1_rsp_done",  rsp_valid, 0);
      check("t1_req_ready_back", req_ready, 1);

      // 2: write, W handshake three cycles before AW
      req_valid = 1; req_wen = 1; req_addr = 32'h8000_0010;
      req_wdata = 32'h1234_5678; req_wstrb = 4'b0011;
      tick();
      req_valid = 0;
      check("t2_awvalid", awvalid, 1);
      check("t2_wvalid",  wvalid, 1);
      check("t2_awaddr",  awaddr, 32'h8000_0010);
      check("t2_wdata",   wdata, 32'h1234_5678);
      check("t2_wstrb",   wstrb, 4'b0011);
      wready = 1;
      tick();
      wready = 0;
      check("t2_wvalid_drop", wvalid, 0);
      check("t2_awvalid_hold", awvalid, 1);
      check("t2_bready_wait", bready, 0);
      repeat (2) begin
         tick();
         check("t2_awvalid_wait", awvalid, 1);
         check("t2_bready_wait2", bready, 0);
         check("t2_awaddr_stable", awaddr, 32'h8000_0010);
      end
      awready = 1;
      tick();
      awready = 0;
      check("t2_awvalid_drop", awvalid, 0);
      check("t2_bready", bready, 1);
      bvalid = 1; bresp = 2'b00;
      tick();
      bvalid = 0;
      check("t2_rsp_valid", rsp_valid, 1);
      check("t2_rsp_err",   rsp_err, 0);
      check("t2_rsp_rdata", rsp_rdata, 0);
      check("t2_bready_drop", bready, 0);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;

      // 3: same-cycle AW/W handshake, SLVERR response
      req_valid = 1; req_wen = 1; req_addr = 32'h8000_0020;
      req_wdata = 32'hAABB_CCDD; req_wstrb = 4'hF;
      tick();
      req_valid = 0;
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0;
      check("t3_awvalid_drop", awvalid, 0);
      check("t3_wvalid_drop",  wvalid, 0);
      check("t3_bready",       bready, 1);
      bvalid = 1; bresp = 2'b10;
      tick();
      bvalid = 0; bresp = 2'b00;
      check("t3_rsp_valid", rsp_valid, 1);
      check("t3_rsp_err",   rsp_err, 1);
      check("t3_rsp_rdata", rsp_rdata, 0);

      // 4: response held while CPU stalls; pending read must not issue
      req_valid = 1; req_wen = 0; req_addr = 32'h9000_0000;
      repeat (5) begin
         tick();
         check("t4_rsp_valid_hold", rsp_valid, 1);
         check("t4_rsp_err_hold",   rsp_err, 1);
         check("t4_rsp_rdata_hold", rsp_rdata, 0);
         check("t4_req_ready_low",  req_ready, 0);
         check("t4_no_ar",          arvalid, 0);
      end
      rsp_ready = 1; req_valid = 0;
      tick();
      rsp_ready = 0;
      check("t4_rsp_done",  rsp_valid, 0);
      check("t4_idle_ready", req_ready, 1);
      check("t4_no_ar_after", arvalid, 0);

      // 5: reset asserted in RD_DATA aborts immediately
      req_valid = 1; req_wen = 0; req_addr = 32'h8000_0040;
      tick();
      req_valid = 0;
      arready = 1;
      tick();
      arready = 0;
      check("t5_in_rd_data", rready, 1);
      #2 rst = 1'b0;
      #1;
      check("t5_arvalid_rst", arvalid, 0);
      check("t5_rready_rst",  rready, 0);
      check("t5_rsp_valid_rst", rsp_valid, 0);
      rvalid = 1; rdata = 32'h5555_5555;
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      rvalid = 0;
      check("t5_req_ready_after", req_ready, 1);
      check("t5_no_late_rsp",     rsp_valid, 0);
      check("t5_rready_after",    rready, 0);

      // 6: slave never accepts AR
      req_valid = 1; req_wen = 0; req_addr = 32'h8000_0080;
      tick();
      req_valid = 0;
`ifdef AXIL_MST_TIMEOUT_EN
      begin
         int hi;
         hi = 0;
         for (int i = 0; i < 100; i++) begin
            if (arvalid) begin
               hi++;
               tick();
            end
         end
         check("t6_arvalid_cycles", hi, 16);
         check("t6_rsp_valid", rsp_valid, 1);
         check("t6_rsp_err",   rsp_err, 1);
         check("t6_rsp_rdata", rsp_rdata, 0);
         check("t6_rready",    rready, 0);
         rsp_ready = 1;
         tick();
         rsp_ready = 0;
         check("t6_req_ready", req_ready, 1);
      end
`else
      repeat (99) tick();
      check("t6_arvalid_still", arvalid, 1);
      check("t6_araddr_still",  araddr, 32'h8000_0080);
      check("t6_no_rsp",        rsp_valid, 0);
      check("t6_req_ready_low", req_ready, 0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("t6_cleanup", arvalid, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
